clock_seq_ctrl: RTL

//  Sequencer for the six cascaded BCD digit counters of the HH:MM:SS clock (decade counters for the ones digits, same-style counters for the tens).

---
 rtl/clock_seq_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/clock_seq_ctrl.sv
// ============================================================================
// Module   : clock_seq_ctrl
// Brief    : HH:MM:SS digit-counter sequencer with time-set FSM and blinking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clock_seq_ctrl #(
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        tick,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [23:0] digits,
    output logic [5:0]  cnt_en,
    output logic [5:0]  cnt_clr,
    output logic [1:0]  mode,
    output logic [5:0]  blank
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_en_q, cnt_en_d;
    logic [5:0]       cnt_clr_q, cnt_clr_d;
    logic [5:0]       blank_q, blank_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic             restart;

    logic [3:0] w_s0, w_s1, w_m0, w_m1, w_h0, w_h1;
    logic [1:0] w_sec_en, w_sec_clr, w_min_en, w_min_clr, w_hr_en, w_hr_clr;
    logic       w_sec_carry, w_min_carry, w_hr_wrap;

    assign {w_h1, w_h0, w_m1, w_m0, w_s1, w_s0} = digits;

    // Ones digit always steps; tens digit steps or clears when ones is at 9.
    assign w_sec_en    = {(w_s0 == 4'd9) && (w_s1 < 4'd5), 1'b1};
    assign w_sec_clr   = {(w_s0 == 4'd9) && (w_s1 >= 4'd5), 1'b0};
    assign w_min_en    = {(w_m0 == 4'd9) && (w_m1 < 4'd5), 1'b1};
    assign w_min_clr   = {(w_m0 == 4'd9) && (w_m1 >= 4'd5), 1'b0};
    assign w_sec_carry = (w_s0 == 4'd9) && (w_s1 >= 4'd5);
    assign w_min_carry = (w_m0 == 4'd9) && (w_m1 >= 4'd5);
    assign w_hr_wrap   = (w_h1 >= 4'd2) && (w_h0 >= 4'd3);
    assign w_hr_en     = w_hr_wrap ? 2'b00 : ((w_h0 == 4'd9) ? 2'b11 : 2'b01);
    assign w_hr_clr    = w_hr_wrap ? 2'b11 : 2'b00;

    always_comb begin
        state_d   = state_q;
        cnt_en_d  = '0;
        cnt_clr_d = '0;
        restart   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (tick) begin
                    cnt_en_d[1:0]  = w_sec_en;
                    cnt_clr_d[1:0] = w_sec_clr;
                    if (w_sec_carry) begin
                        cnt_en_d[3:2]  = w_min_en;
                        cnt_clr_d[3:2] = w_min_clr;
                        if (w_min_carry) begin
                            cnt_en_d[5:4]  = w_hr_en;
                            cnt_clr_d[5:4] = w_hr_clr;
                        end
                    end
                end
                if (btn_mode) begin
                    state_d = ST_SET_HR;
                    restart = 1'b1;
                end
            end
            ST_SET_HR: begin
                if (btn_mode) begin
                    state_d = ST_SET_MIN;
                    restart = 1'b1;
                end else if (btn_inc) begin
                    cnt_en_d[5:4]  = w_hr_en;
                    cnt_clr_d[5:4] = w_hr_clr;
                    restart        = 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (btn_mode) begin
                    state_d        = ST_RUN;
                    cnt_clr_d[1:0] = 2'b11;
                    restart        = 1'b1;
                end else if (btn_inc) begin
                    cnt_en_d[3:2]  = w_min_en;
                    cnt_clr_d[3:2] = w_min_clr;
                    restart        = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                restart = 1'b1;
            end
        endcase

        // Restarting the blink keeps the field visible while it is being stepped.
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
        phase_d     = phase_q;
        if (restart) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == c_cnt_last) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        blank_d = '0;
        if (state_d == ST_SET_HR) begin
            blank_d[5:4] = {2{phase_d}};
        end else if (state_d == ST_SET_MIN) begin
            blank_d[3:2] = {2{phase_d}};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_RUN;
            cnt_en_q    <= '0;
            cnt_clr_q   <= '0;
            blank_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_en_q    <= cnt_en_d;
            cnt_clr_q   <= cnt_clr_d;
            blank_q     <= blank_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign cnt_en  = cnt_en_q;
    assign cnt_clr = cnt_clr_q;
    assign blank   = blank_q;
    assign mode    = state_q;

endmodule

`default_nettype wire
